// File: rtl/seq_data_comp_pkg.sv
// seq_trig_pkg: shared types and default sizes for the sequence trigger.
//   seq_state_t : FSM state (IDLE = not armed, HUNT = searching for sequence)
//   DEF_WIDTH / DEF_DEPTH / DEF_CNT_W : default parameter values
package seq_trig_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HUNT = 1'b1
    } seq_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_data_comp_if.sv
// seq_data_comp_if: serial word stream from the protocol deserialiser.
//   serial_vld  : serial_data holds a new word this cycle
//   serial_data : received word
// Handshake: there is no back-pressure. A word is transferred on every rising
// clock edge where serial_vld is high; serial_data is don't-care otherwise.
interface seq_data_comp_if #(
    parameter int WIDTH = 8
);
    logic             serial_vld;
    logic [WIDTH-1:0] serial_data;

    modport master (output serial_vld, output serial_data);
    modport slave  (input  serial_vld, input  serial_data);
endinterface

// File: rtl/seq_data_comp_stage_cmp.sv
// seq_stage_cmp: one masked word compare (combinational).
//   vld   in  : word qualifier
//   data  in  : received word
//   match in  : expected pattern
//   mask  in  : don't-care bits (1 = ignore)
//   hit   out : vld and all cared-for bits equal
module seq_stage_cmp #(
    parameter int WIDTH = 8
) (
    input  logic             vld,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] match,
    input  logic [WIDTH-1:0] mask,
    output logic             hit
);
    // Forcing masked bits to 1 on both sides makes them compare equal.
    assign hit = vld && ((data | mask) == (match | mask));
endmodule

// File: rtl/seq_data_comp.sv
// seq_data_comp: multi-stage masked sequence trigger.
//   clk, rst    : clock, synchronous active-high reset
//   ser         : serial word stream (slave)
//   arm         : one-cycle arm/re-arm, latches len and mode
//   mode        : 0 = single-shot, 1 = continuous
//   len         : active stages (0 -> 1, >DEPTH -> DEPTH)
//   match, mask : per-stage pattern / don't-care, stage k at [k*WIDTH +: WIDTH]
//   prot_trig   : one-cycle registered pulse on full sequence match
//   armed       : state is HUNT
//   stage       : stage index expected next
//   trig_cnt    : saturating trigger count since reset
//   state_dbg   : current FSM state
module seq_data_comp
    import seq_trig_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W,
    localparam int LEN_W = $clog2(DEPTH + 1),
    localparam int STG_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_data_comp_if.slave         ser,
    input  logic                   arm,
    input  logic                   mode,
    input  logic [LEN_W-1:0]       len,
    input  logic [DEPTH*WIDTH-1:0] match,
    input  logic [DEPTH*WIDTH-1:0] mask,
    output logic                   prot_trig,
    output logic                   armed,
    output logic [STG_W-1:0]       stage,
    output logic [CNT_W-1:0]       trig_cnt,
    output seq_state_t             state_dbg
);

    seq_state_t       state_q, state_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic [LEN_W-1:0] len_q, len_d, len_clamped;
    logic             mode_q, mode_d;
    logic             trig_q, trig_d;
    logic [CNT_W-1:0] cnt_q;
    logic             hit_sel, hit_0;
    logic [STG_W-1:0] last_stage;

    always_comb begin
        len_clamped = len;
        if (len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (len > LEN_W'(DEPTH)) begin
            len_clamped = LEN_W'(DEPTH);
        end
    end

    assign last_stage = STG_W'(len_q - LEN_W'(1));

    // Compare against the currently expected stage.
    seq_stage_cmp #(.WIDTH(WIDTH)) u_cmp_sel (
        .vld   (ser.serial_vld),
        .data  (ser.serial_data),
        .match (match[int'(stage_q)*WIDTH +: WIDTH]),
        .mask  (mask[int'(stage_q)*WIDTH +: WIDTH]),
        .hit   (hit_sel)
    );

    // Stage-0 compare lets a mismatching word immediately restart the sequence.
    seq_stage_cmp #(.WIDTH(WIDTH)) u_cmp_0 (
        .vld   (ser.serial_vld),
        .data  (ser.serial_data),
        .match (match[WIDTH-1:0]),
        .mask  (mask[WIDTH-1:0]),
        .hit   (hit_0)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        len_d   = len_q;
        mode_d  = mode_q;
        trig_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = HUNT;
                    stage_d = '0;
                    len_d   = len_clamped;
                    mode_d  = mode;
                end
            end
            HUNT: begin
                if (hit_sel) begin
                    if (stage_q == last_stage) begin
                        trig_d  = 1'b1;
                        stage_d = '0;
                        if (!mode_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        stage_d = stage_q + STG_W'(1);
                    end
                end else if (ser.serial_vld && stage_q != '0) begin
                    // stage_q > 0 implies len_q >= 2, so a stage-0 hit
                    // can only advance to stage 1 here.
                    stage_d = hit_0 ? STG_W'(1) : '0;
                end
                // Re-arm overrides progress and single-shot disarm, but a
                // same-cycle trigger is still reported.
                if (arm) begin
                    state_d = HUNT;
                    stage_d = '0;
                    len_d   = len_clamped;
                    mode_d  = mode;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            len_q   <= LEN_W'(1);
            mode_q  <= 1'b0;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            trig_q  <= trig_d;
            if (trig_d && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign prot_trig = trig_q;
    assign armed     = (state_q == HUNT);
    assign stage     = stage_q;
    assign trig_cnt  = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_data_comp.sv
// tb_seq_data_comp: directed bench for seq_data_comp. Expected triggers are
// queued as {trig_cnt, armed, stage} when the final word is driven; a monitor
// pops one entry per prot_trig cycle. A second instance with CNT_W=2 checks
// counter saturation.
module tb_seq_data_comp;
    import seq_trig_pkg::*;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        mode;
    logic [2:0]  len;
    logic [31:0] match;
    logic [31:0] mask;
    logic        prot_trig, armed;
    logic [1:0]  stage;
    logic [7:0]  trig_cnt;
    seq_state_t  state_dbg;
    logic        prot_trig2, armed2;
    logic [1:0]  stage2;
    logic [1:0]  trig_cnt2;
    seq_state_t  state_dbg2;

    int tests_run = 0;
    int tests_failed = 0;
    logic [10:0] exp_q[$];

    seq_data_comp_if #(.WIDTH(8)) ser ();

    seq_data_comp #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ser(ser), .arm(arm), .mode(mode), .len(len),
        .match(match), .mask(mask), .prot_trig(prot_trig), .armed(armed),
        .stage(stage), .trig_cnt(trig_cnt), .state_dbg(state_dbg)
    );

    seq_data_comp #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ser(ser), .arm(arm), .mode(mode), .len(len),
        .match(match), .mask(mask), .prot_trig(prot_trig2), .armed(armed2),
        .stage(stage2), .trig_cnt(trig_cnt2), .state_dbg(state_dbg2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every prot_trig cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && prot_trig) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL trig_unexpected: got pulse cnt=%0d expected no pulse", trig_cnt);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if ({trig_cnt, armed, stage} !== e) begin
                    tests_failed++;
                    $display("FAIL trig_state: got cnt=%0d armed=%0b stage=%0d expected cnt=%0d armed=%0b stage=%0d",
                             trig_cnt, armed, stage, e[10:3], e[2], e[1:0]);
                end
            end
        end
    end

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stage(input int k, input logic [7:0] m, input logic [7:0] mk);
        match[k*8 +: 8] = m;
        mask[k*8 +: 8]  = mk;
    endtask

    task automatic do_arm(input logic md, input logic [2:0] ln);
        arm  = 1'b1;
        mode = md;
        len  = ln;
        step();
        arm  = 1'b0;
    endtask

    // Drive one word; if trig is set, queue the expected state at the pulse.
    task automatic word(input logic [7:0] d, input logic trig,
                        input logic [7:0] e_cnt, input logic e_armed);
        ser.serial_vld  = 1'b1;
        ser.serial_data = d;
        if (trig) exp_q.push_back({e_cnt, e_armed, 2'd0});
        step();
        ser.serial_vld  = 1'b0;
        ser.serial_data = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        mode = 1'b0;
        len = 3'd1;
        match = '0;
        mask = '0;
        ser.serial_vld = 1'b0;
        ser.serial_data = 8'h00;
        idle(3);
        rst = 1'b0;
        step();
        check("reset_trig", {31'd0, prot_trig}, 0);
        check("reset_armed", {31'd0, armed}, 0);
        check("reset_stage", {30'd0, stage}, 0);
        check("reset_cnt", {24'd0, trig_cnt}, 0);
        check("reset_state", {31'd0, state_dbg}, {31'd0, IDLE});

        // Single-stage masked compare, single-shot
        set_stage(0, 8'hAB, 8'h0B);
        do_arm(1'b0, 3'd1);
        check("arm_armed", {31'd0, armed}, 1);
        word(8'hA0, 1'b1, 8'd1, 1'b0);
        check("ss_disarm", {31'd0, armed}, 0);
        step();
        check("pulse_one_cycle", {31'd0, prot_trig}, 0);
        set_stage(0, 8'h01, 8'h00);
        do_arm(1'b0, 3'd1);
        word(8'h11, 1'b0, 8'd0, 1'b0);
        check("nomatch_armed", {31'd0, armed}, 1);
        check("nomatch_cnt", {24'd0, trig_cnt}, 1);

        // Three stages with gaps
        set_stage(0, 8'h55, 8'h00);
        set_stage(1, 8'hAA, 8'h00);
        set_stage(2, 8'hF0, 8'h00);
        do_arm(1'b0, 3'd3);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        check("seq_stage1", {30'd0, stage}, 1);
        idle(3);
        check("gap_hold", {30'd0, stage}, 1);
        word(8'hAA, 1'b0, 8'd0, 1'b0);
        check("seq_stage2", {30'd0, stage}, 2);
        word(8'hF0, 1'b1, 8'd2, 1'b0);
        check("seq_stage0", {30'd0, stage}, 0);

        // Restart on stage-0 hit
        do_arm(1'b0, 3'd3);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        check("restart_stage1", {30'd0, stage}, 1);
        word(8'hAA, 1'b0, 8'd0, 1'b0);
        word(8'hF0, 1'b1, 8'd3, 1'b0);
        do_arm(1'b0, 3'd3);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        word(8'h12, 1'b0, 8'd0, 1'b0);
        check("restart_to0", {30'd0, stage}, 0);
        word(8'hAA, 1'b0, 8'd0, 1'b0);
        word(8'hF0, 1'b0, 8'd0, 1'b0);
        check("restart_nohit_stage", {30'd0, stage}, 0);
        check("restart_nohit_cnt", {24'd0, trig_cnt}, 3);

        // Continuous, two stages
        do_arm(1'b1, 3'd2);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        word(8'hAA, 1'b1, 8'd4, 1'b1);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        word(8'hAA, 1'b1, 8'd5, 1'b1);
        check("cont_armed", {31'd0, armed}, 1);
        check("cont_cnt", {24'd0, trig_cnt}, 5);

        // Reset mid-sequence, then unarmed stream
        do_arm(1'b0, 3'd3);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        word(8'hAA, 1'b0, 8'd0, 1'b0);
        check("mid_stage2", {30'd0, stage}, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_stage", {30'd0, stage}, 0);
        check("rst_armed", {31'd0, armed}, 0);
        check("rst_cnt", {24'd0, trig_cnt}, 0);
        word(8'hF0, 1'b0, 8'd0, 1'b0);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        word(8'hAA, 1'b0, 8'd0, 1'b0);
        word(8'hF0, 1'b0, 8'd0, 1'b0);
        check("unarmed_cnt", {24'd0, trig_cnt}, 0);

        // Back-to-back continuous len=1 hits, saturation on the narrow counter
        do_arm(1'b1, 3'd0);
        for (int i = 1; i <= 5; i++) word(8'h55, 1'b1, 8'(i), 1'b1);
        check("sat_cnt2", {30'd0, trig_cnt2}, 3);
        check("wide_cnt", {24'd0, trig_cnt}, 5);

        // Arm coincident with final hit: pulse counts, arm wins, new mode latched
        arm = 1'b1;
        mode = 1'b0;
        len = 3'd1;
        word(8'h55, 1'b1, 8'd6, 1'b1);
        arm = 1'b0;
        check("arm_hit_armed", {31'd0, armed}, 1);
        word(8'h55, 1'b1, 8'd7, 1'b0);
        check("arm_hit_disarm", {31'd0, armed}, 0);

        // Clamp: len > DEPTH behaves as DEPTH
        set_stage(3, 8'h3C, 8'h00);
        do_arm(1'b0, 3'd7);
        word(8'h55, 1'b0, 8'd0, 1'b0);
        word(8'hAA, 1'b0, 8'd0, 1'b0);
        word(8'hF0, 1'b0, 8'd0, 1'b0);
        check("clamp_stage3", {30'd0, stage}, 3);
        word(8'h3C, 1'b1, 8'd8, 1'b0);

        idle(4);
        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
